// File: rtl/if_fetch_stage_pkg.sv
// Shared constants for the instruction-fetch stage: word width, FSM encoding,
// default PC step and NOP encoding, plus the halfword alignment helper.
package if_fetch_stage_pkg;

    localparam int WORD_W = 16;

    localparam logic [WORD_W-1:0] DEF_PC_STEP   = 16'd2;
    localparam logic [WORD_W-1:0] DEF_NOP_INSTR = 16'h0000;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_BUF   = 2'd2;
    localparam logic [1:0] ST_KILL  = 2'd3;

    // Instructions are halfword aligned, so bit 0 of any redirect is dropped.
    function automatic logic [WORD_W-1:0] align_pc(input logic [WORD_W-1:0] addr);
        return addr & {{(WORD_W-1){1'b1}}, 1'b0};
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a returned instruction and its pc+2 while
// the IF/ID register is stalled. Only the full flag is reset.
module fetch_skid_buffer
    import if_fetch_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              drain,
    input  logic [WORD_W-1:0] instr_in,
    input  logic [WORD_W-1:0] pc_plus2_in,
    output logic              full,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] pc_plus2
);

    always_ff @(posedge clk) begin
        if (reset) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            instr    <= instr_in;
            pc_plus2 <= pc_plus2_in;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, imem request handshake, IF/ID register,
// branch redirect/squash handling and a one-entry skid buffer for stalls.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC  = 16'h0000,
    parameter logic [WORD_W-1:0] PC_STEP   = DEF_PC_STEP,
    parameter logic [WORD_W-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              PCSrc,
    input  logic [WORD_W-1:0] branch_target,
    input  logic              stall_IF,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic [WORD_W-1:0] IFID_instr,
    output logic [WORD_W-1:0] IFID_pc_plus2,
    output logic              IFID_valid
);

    logic [1:0]        state;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc_seq;
    logic [WORD_W-1:0] redirect_pc;
    logic [WORD_W-1:0] kill_addr;
    logic              skid_load;
    logic              skid_drain;
    logic              skid_full;
    logic [WORD_W-1:0] skid_instr;
    logic [WORD_W-1:0] skid_pc_plus2;

    assign pc_seq      = pc + PC_STEP;
    assign redirect_pc = align_pc(branch_target);

    // While squashing, the request stays on the old address until memory answers.
    assign imem_req  = (state == ST_FETCH) || (state == ST_KILL);
    assign imem_addr = (state == ST_KILL) ? kill_addr : pc;

    assign skid_load  = (state == ST_FETCH) && imem_ready && stall_IF && !PCSrc;
    assign skid_drain = (state == ST_BUF) && (PCSrc || !stall_IF);

    fetch_skid_buffer u_skid (
        .clk         (clk),
        .reset       (reset),
        .load        (skid_load),
        .drain       (skid_drain),
        .instr_in    (imem_rdata),
        .pc_plus2_in (pc_seq),
        .full        (skid_full),
        .instr       (skid_instr),
        .pc_plus2    (skid_pc_plus2)
    );

    always_ff @(posedge clk) begin
        if (state == ST_FETCH && PCSrc && !imem_ready) begin
            kill_addr <= pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            pc            <= RESET_PC;
            IFID_instr    <= NOP_INSTR;
            IFID_pc_plus2 <= '0;
            IFID_valid    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (PCSrc) begin
                        IFID_valid <= 1'b0;
                        IFID_instr <= NOP_INSTR;
                        pc         <= redirect_pc;
                        if (!imem_ready) begin
                            state <= ST_KILL;
                        end
                    end else if (imem_ready) begin
                        pc <= pc_seq;
                        if (stall_IF) begin
                            state <= ST_BUF;
                        end else begin
                            IFID_instr    <= imem_rdata;
                            IFID_pc_plus2 <= pc_seq;
                            IFID_valid    <= 1'b1;
                        end
                    end else if (!stall_IF) begin
                        IFID_valid <= 1'b0;
                    end
                end
                ST_BUF: begin
                    if (PCSrc) begin
                        IFID_valid <= 1'b0;
                        IFID_instr <= NOP_INSTR;
                        pc         <= redirect_pc;
                        state      <= ST_FETCH;
                    end else if (!stall_IF && skid_full) begin
                        IFID_instr    <= skid_instr;
                        IFID_pc_plus2 <= skid_pc_plus2;
                        IFID_valid    <= 1'b1;
                        state         <= ST_FETCH;
                    end
                end
                ST_KILL: begin
                    if (PCSrc) begin
                        IFID_valid <= 1'b0;
                        IFID_instr <= NOP_INSTR;
                        pc         <= redirect_pc;
                    end
                    // The squashed response is dropped; fetch resumes at the latest target.
                    if (imem_ready) begin
                        state <= ST_FETCH;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: memory model with configurable wait states,
// scoreboard of expected IF/ID contents, directed scenarios plus random traffic.
module tb_if_fetch_stage;

    logic        clk;
    logic        reset;
    logic        PCSrc;
    logic [15:0] branch_target;
    logic        stall_IF;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic [15:0] IFID_instr;
    logic [15:0] IFID_pc_plus2;
    logic        IFID_valid;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   waits    = 0;
    int   wcnt     = 0;
    int   consumed = 0;
    logic ready_ovr = 1'b0;
    logic ready_val = 1'b0;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pp2;
    } item_t;

    item_t       sb[$];
    logic [15:0] exp_pc    = 16'h0000;
    logic [15:0] prev_addr = 16'h0000;
    logic        kill_pend = 1'b0;
    logic        prev_wait = 1'b0;

    if_fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .PCSrc         (PCSrc),
        .branch_target (branch_target),
        .stall_IF      (stall_IF),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .IFID_instr    (IFID_instr),
        .IFID_pc_plus2 (IFID_pc_plus2),
        .IFID_valid    (IFID_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC3A5;
    endfunction

    assign imem_rdata = mem_word(imem_addr);
    assign imem_ready = ready_ovr ? ready_val : (imem_req && (wcnt >= waits));

    always @(posedge clk) begin
        if (reset || !imem_req || imem_ready) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: responses are pushed when accepted, popped when ID consumes IF/ID.
    always @(negedge clk) begin
        item_t it;
        if (reset) begin
            sb.delete();
            exp_pc    = 16'h0000;
            kill_pend = 1'b0;
            prev_wait = 1'b0;
        end else begin
            if (prev_wait) begin
                check_eq("hs_req_held", {15'd0, imem_req}, 16'd1);
                check_eq("hs_addr_held", imem_addr, prev_addr);
            end
            if (imem_req && !kill_pend) check_eq("fetch_addr", imem_addr, exp_pc);
            if (IFID_valid && !stall_IF && !PCSrc) begin
                if (sb.size() == 0) begin
                    check_eq("ifid_unexpected", {15'd0, IFID_valid}, 16'd0);
                end else begin
                    it = sb.pop_front();
                    check_eq("ifid_instr", IFID_instr, it.instr);
                    check_eq("ifid_pc_plus2", IFID_pc_plus2, it.pp2);
                    consumed++;
                end
            end
            if (PCSrc) begin
                sb.delete();
                kill_pend = imem_req && !imem_ready;
                exp_pc    = branch_target & 16'hFFFE;
            end else if (imem_req && imem_ready) begin
                if (kill_pend) begin
                    kill_pend = 1'b0;
                end else begin
                    it.instr = imem_rdata;
                    it.pp2   = exp_pc + 16'd2;
                    sb.push_back(it);
                    exp_pc = exp_pc + 16'd2;
                end
            end
            prev_wait = imem_req && !imem_ready;
            prev_addr = imem_addr;
        end
    end

    initial begin
        reset = 1'b1;
        PCSrc = 1'b0;
        branch_target = 16'h0000;
        stall_IF = 1'b0;
        tick();
        tick();
        check_eq("rst_req", {15'd0, imem_req}, 16'd0);
        check_eq("rst_valid", {15'd0, IFID_valid}, 16'd0);
        check_eq("rst_instr", IFID_instr, 16'h0000);
        check_eq("rst_pp2", IFID_pc_plus2, 16'h0000);
        reset = 1'b0;

        // Zero-wait sequential fetch
        tick();
        check_eq("seq_addr0", imem_addr, 16'h0000);
        check_eq("seq_req", {15'd0, imem_req}, 16'd1);
        tick();
        check_eq("seq_addr1", imem_addr, 16'h0002);
        check_eq("seq_pp2_1", IFID_pc_plus2, 16'h0002);
        check_eq("seq_valid", {15'd0, IFID_valid}, 16'd1);
        tick();
        check_eq("seq_addr2", imem_addr, 16'h0004);
        check_eq("seq_pp2_2", IFID_pc_plus2, 16'h0004);
        tick();
        check_eq("seq_addr3", imem_addr, 16'h0006);
        check_eq("seq_pp2_3", IFID_pc_plus2, 16'h0006);

        // Stall into the skid buffer for three cycles
        stall_IF = 1'b1;
        tick();
        check_eq("buf_req", {15'd0, imem_req}, 16'd0);
        tick();
        tick();
        check_eq("buf_req_hold", {15'd0, imem_req}, 16'd0);
        check_eq("buf_pp2_frozen", IFID_pc_plus2, 16'h0006);
        check_eq("buf_instr_frozen", IFID_instr, mem_word(16'h0004));
        stall_IF = 1'b0;
        tick();
        check_eq("drain_instr", IFID_instr, mem_word(16'h0006));
        check_eq("drain_pp2", IFID_pc_plus2, 16'h0008);
        check_eq("drain_addr", imem_addr, 16'h0008);

        // Branch while stalled
        stall_IF = 1'b1;
        PCSrc = 1'b1;
        branch_target = 16'h0041;
        tick();
        check_eq("br_valid", {15'd0, IFID_valid}, 16'd0);
        check_eq("br_instr", IFID_instr, 16'h0000);
        check_eq("br_addr", imem_addr, 16'h0040);
        PCSrc = 1'b0;
        stall_IF = 1'b0;
        tick();

        // Branch during the first wait state of a 2-wait memory
        waits = 2;
        PCSrc = 1'b1;
        branch_target = 16'h0100;
        tick();
        PCSrc = 1'b0;
        check_eq("kill_req", {15'd0, imem_req}, 16'd1);
        check_eq("kill_addr0", imem_addr, 16'h0042);
        check_eq("kill_valid0", {15'd0, IFID_valid}, 16'd0);
        tick();
        check_eq("kill_addr1", imem_addr, 16'h0042);
        tick();
        check_eq("kill_redirect", imem_addr, 16'h0100);
        check_eq("kill_valid1", {15'd0, IFID_valid}, 16'd0);

        // PC wrap at the top of the address space
        waits = 0;
        PCSrc = 1'b1;
        branch_target = 16'hFFFE;
        tick();
        PCSrc = 1'b0;
        check_eq("wrap_addr", imem_addr, 16'hFFFE);
        tick();
        check_eq("wrap_pp2", IFID_pc_plus2, 16'h0000);
        check_eq("wrap_instr", IFID_instr, mem_word(16'hFFFE));
        check_eq("wrap_next", imem_addr, 16'h0000);
        tick();

        // Reset while a squashed request is outstanding
        waits = 3;
        PCSrc = 1'b1;
        branch_target = 16'h0200;
        tick();
        PCSrc = 1'b0;
        check_eq("rk_held", imem_addr, 16'h0002);
        reset = 1'b1;
        ready_ovr = 1'b1;
        ready_val = 1'b1;
        tick();
        check_eq("rk_req", {15'd0, imem_req}, 16'd0);
        check_eq("rk_valid", {15'd0, IFID_valid}, 16'd0);
        check_eq("rk_pc", imem_addr, 16'h0000);
        reset = 1'b0;
        ready_ovr = 1'b0;
        waits = 0;
        tick();
        check_eq("rk_fetch_req", {15'd0, imem_req}, 16'd1);
        check_eq("rk_fetch_addr", imem_addr, 16'h0000);

        // Random stalls, branches and wait states
        for (int i = 0; i < 400; i++) begin
            stall_IF = ($urandom_range(0, 9) < 3);
            PCSrc = ($urandom_range(0, 11) == 0);
            branch_target = 16'($urandom);
            if ($urandom_range(0, 15) == 0) waits = $urandom_range(0, 2);
            tick();
        end
        stall_IF = 1'b0;
        PCSrc = 1'b0;
        waits = 0;
        for (int i = 0; i < 6; i++) tick();
        check_eq("consumed_any", {15'd0, (consumed > 20)}, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
